// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> ADDR -> MEM -> ISSUE (-> JUMP) over a shared 16-bit tristate bus.
// Optional FETCH_TIMEOUT_EN adds a memory wait-state watchdog that raises a sticky fault and halts.
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [15:0] bus,
  output logic        pc_en_bar,
  output logic        pc_load_bar,
  output logic        pc_inc,
  output logic        mem_rd_bar,
  input  logic        mem_ready,
  output logic [15:0] addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        jump_req,
  input  logic [15:0] jump_addr,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, ADDR, MEM, ISSUE, JUMP, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] jtgt_q, jtgt_d;
  logic        pc_en_bar_q, pc_en_bar_d;
  logic        pc_load_bar_q, pc_load_bar_d;
  logic        mem_rd_bar_q, mem_rd_bar_d;
  logic        valid_q, valid_d;
  logic        bus_oe_q, bus_oe_d;
`ifdef FETCH_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    jtgt_d  = jtgt_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE:  state_d = ADDR;
      ADDR: begin
        addr_d  = bus;
        state_d = MEM;
      end
      MEM: begin
        if (mem_ready) begin
          instr_d = bus;
          state_d = ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == 8'd254) begin
          cnt_d   = 8'd255;
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ISSUE: begin
        // A redirect is only honoured together with the consumer's acceptance.
        if (instr_ack) begin
          if (jump_req) begin
            jtgt_d  = jump_addr;
            state_d = JUMP;
          end else begin
            state_d = ADDR;
          end
        end
      end
      JUMP:    state_d = ADDR;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
`ifdef FETCH_TIMEOUT_EN
    if (state_d == MEM && state_q != MEM) cnt_d = 8'd0;
`endif
    // Strobes are decoded from the next state so they leave a flop cleanly.
    pc_en_bar_d   = (state_d != ADDR);
    mem_rd_bar_d  = (state_d != MEM);
    pc_load_bar_d = (state_d != JUMP);
    bus_oe_d      = (state_d == JUMP);
    valid_d       = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= 16'h0000;
      instr_q       <= 16'h0000;
      jtgt_q        <= 16'h0000;
      pc_en_bar_q   <= 1'b1;
      pc_load_bar_q <= 1'b1;
      mem_rd_bar_q  <= 1'b1;
      valid_q       <= 1'b0;
      bus_oe_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q         <= 8'd0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      instr_q       <= instr_d;
      jtgt_q        <= jtgt_d;
      pc_en_bar_q   <= pc_en_bar_d;
      pc_load_bar_q <= pc_load_bar_d;
      mem_rd_bar_q  <= mem_rd_bar_d;
      valid_q       <= valid_d;
      bus_oe_q      <= bus_oe_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q         <= cnt_d;
      fault_q       <= fault_d;
`endif
    end
  end

  // pc_inc qualifies the registered read strobe with this cycle's ready.
  assign pc_inc      = ~mem_rd_bar_q & mem_ready;
  assign bus         = bus_oe_q ? jtgt_q : 16'hzzzz;
  assign pc_en_bar   = pc_en_bar_q;
  assign pc_load_bar = pc_load_bar_q;
  assign mem_rd_bar  = mem_rd_bar_q;
  assign addr        = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
`ifdef FETCH_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: external PC and memory (mem[n] = n + 0x100) sit on the shared bus.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  wire  [15:0] bus;
  logic        pc_en_bar, pc_load_bar, pc_inc, mem_rd_bar;
  logic        mem_ready = 1'b1;
  logic [15:0] addr, instr;
  logic        instr_valid;
  logic        instr_ack = 1'b1;
  logic        jump_req = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        fault;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pc_en_bar(pc_en_bar), .pc_load_bar(pc_load_bar), .pc_inc(pc_inc),
    .mem_rd_bar(mem_rd_bar), .mem_ready(mem_ready),
    .addr(addr), .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .jump_req(jump_req), .jump_addr(jump_addr), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [15:0] pc = 16'h0000;
  always @(posedge clk) begin
    if (pc_inc) pc <= pc + 16'd1;
    else if (!pc_load_bar) pc <= bus;
  end
  assign bus = !pc_en_bar ? pc : (!mem_rd_bar ? (addr + 16'h0100) : 16'hzzzz);

  typedef struct {
    logic        rdy, ack;
    logic        en_b, rd_b, inc, ld_b, vld;
    logic [15:0] a, d;
  } vec_t;

  typedef struct {
    logic [15:0] a, d;
  } sb_t;

  vec_t tbl [10];
  sb_t  sb [$];
  int   checks = 0;
  int   errors = 0;
  int   n_pop = 0;
  int   inv_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // One cycle: settle inputs, check invariants and scoreboard, advance to edge+1.
  task automatic step();
    sb_t e;
    logic [15:0] nxt;
    #1;
    if ($countones({~pc_en_bar, ~mem_rd_bar, ~pc_load_bar}) > 1 || (pc_inc && !pc_load_bar))
      inv_bad++;
    if (instr_valid && instr_ack) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", addr, e.a);
        chk("sb_instr", instr, e.d);
        n_pop++;
        nxt = jump_req ? jump_addr : e.a + 16'd1;
        sb.push_back('{nxt, nxt + 16'h0100});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input logic jr, input logic [15:0] ja);
    int n0;
    n0 = n_pop;
    instr_ack = 1'b1;
    mem_ready = 1'b1;
    jump_req  = jr;
    jump_addr = ja;
    for (int i = 0; i < 50 && n_pop == n0; i++) step();
    jump_req = 1'b0;
    chk("hs_reached", n_pop - n0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd_low, inc_n, bad, n;
    logic [15:0] pc_before;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0100};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0100};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0101};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0101};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0101};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h0102};
    sb.push_back('{16'h0000, 16'h0100});

    #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_en_bar", pc_en_bar, 1);
    chk("rst_mem_rd_bar", mem_rd_bar, 1);
    chk("rst_pc_load_bar", pc_load_bar, 1);
    chk("rst_pc_inc", pc_inc, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      mem_ready = tbl[i].rdy;
      instr_ack = tbl[i].ack;
      #1;
      chk($sformatf("t%0d_pc_en_bar", i), pc_en_bar, tbl[i].en_b);
      chk($sformatf("t%0d_mem_rd_bar", i), mem_rd_bar, tbl[i].rd_b);
      chk($sformatf("t%0d_pc_inc", i), pc_inc, tbl[i].inc);
      chk($sformatf("t%0d_pc_load_bar", i), pc_load_bar, tbl[i].ld_b);
      chk($sformatf("t%0d_instr_valid", i), instr_valid, tbl[i].vld);
      chk($sformatf("t%0d_addr", i), addr, tbl[i].a);
      chk($sformatf("t%0d_instr", i), instr, tbl[i].d);
      step();
    end

    // Five wait states on the fetch from 0x0003.
    mem_ready = 1'b0;
    instr_ack = 1'b0;
    chk("ws_addr_phase", pc_en_bar, 0);
    step();
    chk("ws_addr", addr, 16'h0003);
    rd_low = 0;
    inc_n  = 0;
    for (int k = 0; k < 6; k++) begin
      mem_ready = (k == 5);
      #1;
      if (!mem_rd_bar) rd_low++;
      if (pc_inc) inc_n++;
      step();
    end
    mem_ready = 1'b1;
    chk("ws_rd_low_cycles", rd_low, 6);
    chk("ws_pc_inc_cycles", inc_n, 1);
    chk("ws_instr", instr, 16'h0103);
    chk("ws_mem_rd_released", mem_rd_bar, 1);

    // Consumer stalls; a redirect without acceptance must not take effect.
    jump_req  = 1'b1;
    jump_addr = 16'hBEEF;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!(instr_valid && instr == 16'h0103 && pc_en_bar && mem_rd_bar && !pc_inc && pc_load_bar))
        bad++;
      step();
    end
    chk("stall_hold_bad_cycles", bad, 0);

    instr_ack = 1'b1;
    jump_addr = 16'h1234;
    step();
    jump_req  = 1'b0;
    jump_addr = 16'h0000;
    #1;
    chk("jump_pc_load_bar", pc_load_bar, 0);
    chk("jump_bus", bus, 16'h1234);
    chk("jump_pc_inc", pc_inc, 0);
    chk("jump_pc_en_bar", pc_en_bar, 1);
    step();
    chk("jump_pc_drive", bus, 16'h1234);
    step();
    chk("jump_addr_latched", addr, 16'h1234);

    // Wrap from 0xFFFF back to 0x0000.
    wait_hs(1'b1, 16'hFFFF);
    wait_hs(1'b0, 16'h0000);
    wait_hs(1'b0, 16'h0000);

    // Reset in the middle of a memory wait.
    mem_ready = 1'b0;
    for (int i = 0; i < 20 && mem_rd_bar; i++) step();
    chk("mid_mem_reached", mem_rd_bar, 0);
    pc_before = pc;
    reset = 1'b1;
    #1;
    chk("mr_pc_en_bar", pc_en_bar, 1);
    chk("mr_mem_rd_bar", mem_rd_bar, 1);
    chk("mr_pc_inc", pc_inc, 0);
    chk("mr_pc_load_bar", pc_load_bar, 1);
    chk("mr_instr_valid", instr_valid, 0);
    chk("mr_addr", addr, 0);
    chk("mr_instr", instr, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mr_pc_unchanged", pc, pc_before);
    reset = 1'b0;
    wait_hs(1'b0, 16'h0000);

    // Memory never ready.
    mem_ready = 1'b0;
    for (int i = 0; i < 20 && mem_rd_bar; i++) step();
    chk("to_mem_reached", mem_rd_bar, 0);
`ifdef FETCH_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 400 && !fault; i++) begin
      if (!mem_rd_bar) n++;
      step();
    end
    chk("to_wait_cycles", n, 255);
    chk("to_fault", fault, 1);
    chk("to_mem_rd_released", mem_rd_bar, 1);
    mem_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!(fault && mem_rd_bar && pc_en_bar && pc_load_bar && !pc_inc && !instr_valid)) bad++;
      step();
    end
    chk("halt_hold_bad_cycles", bad, 0);
`else
    n = 0;
    repeat (300) begin
      if (!mem_rd_bar) n++;
      step();
    end
    chk("nto_wait_cycles", n, 300);
    chk("nto_still_waiting", mem_rd_bar, 0);
    chk("nto_fault", fault, 0);
`endif

    chk("invariant_bad_cycles", inv_bad, 0);
    chk("handshakes", n_pop, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
